twpm_wb_decoder: RTL and testbench

//  Wishbone address decoder between the NEORV32 master port and the four TwPM slaves:
//  TPM regs, TPM cmd/rsp RAM, LiteDRAM controller and DDR3 RAM.

---
 rtl/twpm_wb_if.sv | 64 ++++++
 rtl/twpm_wb_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_twpm_wb_decoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/twpm_wb_if.sv
// Wishbone bundle between the NEORV32 master port, the TwPM address decoder
// and the four TwPM slaves.
interface twpm_wb_if;
  logic [31:0]  m_wb_adr_i;
  logic [31:0]  m_wb_dat_i;
  logic         m_wb_we_i;
  logic [3:0]   m_wb_sel_i;
  logic         m_wb_stb_i;
  logic         m_wb_cyc_i;
  logic [31:0]  m_wb_dat_o;
  logic         m_wb_ack_o;
  logic         m_wb_err_o;
  logic [31:0]  s_wb_adr_o;
  logic [31:0]  s_wb_dat_o;
  logic [3:0]   s_wb_sel_o;
  logic         s_wb_we_o;
  logic         s_wb_cyc_o;
  logic [3:0]   s_wb_stb_o;
  logic [3:0]   s_wb_ack_i;
  logic [3:0]   s_wb_err_i;
  logic [127:0] s_wb_dat_i;

  modport slave (
    input  m_wb_adr_i,
    input  m_wb_dat_i,
    input  m_wb_we_i,
    input  m_wb_sel_i,
    input  m_wb_stb_i,
    input  m_wb_cyc_i,
    output m_wb_dat_o,
    output m_wb_ack_o,
    output m_wb_err_o,
    output s_wb_adr_o,
    output s_wb_dat_o,
    output s_wb_sel_o,
    output s_wb_we_o,
    output s_wb_cyc_o,
    output s_wb_stb_o,
    input  s_wb_ack_i,
    input  s_wb_err_i,
    input  s_wb_dat_i
  );

  modport master (
    output m_wb_adr_i,
    output m_wb_dat_i,
    output m_wb_we_i,
    output m_wb_sel_i,
    output m_wb_stb_i,
    output m_wb_cyc_i,
    input  m_wb_dat_o,
    input  m_wb_ack_o,
    input  m_wb_err_o,
    input  s_wb_adr_o,
    input  s_wb_dat_o,
    input  s_wb_sel_o,
    input  s_wb_we_o,
    input  s_wb_cyc_o,
    input  s_wb_stb_o,
    output s_wb_ack_i,
    output s_wb_err_i,
    output s_wb_dat_i
  );
endinterface

// File: rtl/twpm_wb_decoder.sv
// Wishbone decoder: NEORV32 master to TPM regs, TPM RAM, LiteDRAM ctrl, DDR3.
// Registered select/response path with unmapped and timeout error answers.
module twpm_wb_decoder #(
  parameter logic [31:0] S0_BASE    = 32'hF000_0000,
  parameter int          S0_AW      = 11,
  parameter logic [31:0] S1_BASE    = 32'hF000_0800,
  parameter int          S1_AW      = 11,
  parameter logic [31:0] S2_BASE    = 32'hF800_0000,
  parameter int          S2_AW      = 14,
  parameter logic [31:0] S3_BASE    = 32'h8000_0000,
  parameter int          S3_AW      = 27,
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] DEFAULT_RD = 32'hBADF_ABAC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  twpm_wb_if.slave    bus,
  output logic [15:0] err_cnt_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  function automatic logic hit_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          aw
  );
    return (a >> aw) == (b >> aw);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        was_q, was_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  stb_q, stb_d;
  logic [31:0] mdat_q, mdat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [31:0] eadr_q, eadr_d;

  logic [3:0]  hit;
  logic [1:0]  hit_idx;
  logic        s_ack;
  logic        s_err;
  logic [31:0] s_dat;
  logic        do_err;
  logic [31:0] err_adr;

  assign hit[0] = hit_f(bus.m_wb_adr_i, S0_BASE, S0_AW);
  assign hit[1] = hit_f(bus.m_wb_adr_i, S1_BASE, S1_AW);
  assign hit[2] = hit_f(bus.m_wb_adr_i, S2_BASE, S2_AW);
  assign hit[3] = hit_f(bus.m_wb_adr_i, S3_BASE, S3_AW);

  // overlapping windows resolve to the lowest slave index
  always_comb begin
    hit_idx = 2'd0;
    priority case (1'b1)
      hit[0]:  hit_idx = 2'd0;
      hit[1]:  hit_idx = 2'd1;
      hit[2]:  hit_idx = 2'd2;
      hit[3]:  hit_idx = 2'd3;
      default: hit_idx = 2'd0;
    endcase
  end

  assign s_ack = bus.s_wb_ack_i[idx_q];
  assign s_err = bus.s_wb_err_i[idx_q];
  assign s_dat = bus.s_wb_dat_i[{idx_q, 5'd0} +: 32];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    was_d   = (state_q == RESP);
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    mdat_d  = mdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    eadr_d  = eadr_q;
    do_err  = 1'b0;
    err_adr = adr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m_wb_cyc_i && bus.m_wb_stb_i && !was_q) begin
          adr_d = bus.m_wb_adr_i;
          dat_d = bus.m_wb_dat_i;
          sel_d = bus.m_wb_sel_i;
          we_d  = bus.m_wb_we_i;
          if (|hit) begin
            state_d = BUSY;
            idx_d   = hit_idx;
            stb_d   = 4'(1) << hit_idx;
            cyc_d   = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            state_d = RESP;
            do_err  = 1'b1;
            err_adr = bus.m_wb_adr_i;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (s_err || s_ack || cnt_q == TO_LAST) begin
          state_d = RESP;
          stb_d   = 4'd0;
          cyc_d   = 1'b0;
          if (!s_err && s_ack) begin
            ack_d  = 1'b1;
            mdat_d = s_dat;
          end else begin
            do_err = 1'b1;
          end
        end else if (!bus.m_wb_cyc_i) begin
          state_d = IDLE;
          stb_d   = 4'd0;
          cyc_d   = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_err) begin
      err_d  = 1'b1;
      mdat_d = DEFAULT_RD;
      eadr_d = err_adr;
      if (ecnt_q != 16'hFFFF) begin
        ecnt_d = ecnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 16'd0;
      was_q   <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 4'd0;
      mdat_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= 16'd0;
      eadr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      was_q   <= was_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      mdat_q  <= mdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      eadr_q  <= eadr_d;
    end
  end

  assign bus.m_wb_dat_o = mdat_q;
  assign bus.m_wb_ack_o = ack_q;
  assign bus.m_wb_err_o = err_q;
  assign bus.s_wb_adr_o = adr_q;
  assign bus.s_wb_dat_o = dat_q;
  assign bus.s_wb_sel_o = sel_q;
  assign bus.s_wb_we_o  = we_q;
  assign bus.s_wb_cyc_o = cyc_q;
  assign bus.s_wb_stb_o = stb_q;
  assign err_cnt_o      = ecnt_q;
  assign err_addr_o     = eadr_q;

endmodule

// File: tb/tb_twpm_wb_decoder.sv
// Scoreboard bench for twpm_wb_decoder with a behavioural slave model.
// Expected responses are queued at request time and popped on ack/err.
module tb_twpm_wb_decoder;

  localparam logic [31:0] DEF = 32'hBADF_ABAC;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic [15:0] cnt;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;

  twpm_wb_if wb ();

  twpm_wb_decoder #(
    .TIMEOUT(16)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (wb),
    .err_cnt_o (err_cnt),
    .err_addr_o(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nchk = 0;
  int          nerr = 0;
  exp_t        sb[$];
  logic [15:0] m_cnt = 16'd0;
  logic [31:0] m_addr = 32'd0;

  // slave model knobs: mode bit0 = ack, bit1 = err
  logic [1:0]  sl_mode = 2'd0;
  int          sl_delay = 0;
  logic [31:0] sl_data = 32'd0;
  int          stb_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    n = -1;
    for (int k = 0; k < 4; k++)
      if (wb.s_wb_stb_o[k] === 1'b1) n = k;
    wb.s_wb_ack_i = 4'd0;
    wb.s_wb_err_i = 4'd0;
    for (int k = 0; k < 4; k++)
      wb.s_wb_dat_i[32*k +: 32] = (k == n) ? sl_data
                                           : (32'hDEAD_0000 | 32'(k));
    if (n < 0) begin
      stb_cnt = 0;
    end else begin
      if (stb_cnt == sl_delay) begin
        wb.s_wb_ack_i[n] = sl_mode[0];
        wb.s_wb_err_i[n] = sl_mode[1];
      end
      stb_cnt++;
    end
  end

  logic prev_resp = 1'b0;
  logic resp;
  exp_t e;

  always @(negedge clk) begin
    resp = (wb.m_wb_ack_o === 1'b1) || (wb.m_wb_err_o === 1'b1);
    if (resp) begin
      chk("1cyc", 32'(prev_resp), 32'd0);
      chk("sb_has", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("m_err", 32'(wb.m_wb_err_o), 32'(e.err));
        chk("m_ack", 32'(wb.m_wb_ack_o), 32'(!e.err));
        chk("m_dat", wb.m_wb_dat_o, e.dat);
        chk("e_cnt", 32'(err_cnt), 32'(e.cnt));
        chk("e_adr", err_addr, e.addr);
      end
    end
    prev_resp = resp;
  end

  task automatic xfer(input logic [31:0] a,
                      input logic        w,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input logic [3:0]  exp_stb,
                      input logic        exp_err,
                      input logic [31:0] exp_dat,
                      input int          exp_lat);
    int n;
    exp_t x;
    @(negedge clk);
    wb.m_wb_adr_i = a;
    wb.m_wb_dat_i = d;
    wb.m_wb_we_i  = w;
    wb.m_wb_sel_i = s;
    wb.m_wb_cyc_i = 1'b1;
    wb.m_wb_stb_i = 1'b1;
    if (exp_err) begin
      m_cnt  = m_cnt + 16'd1;
      m_addr = a;
    end
    x.err  = exp_err;
    x.dat  = exp_dat;
    x.cnt  = m_cnt;
    x.addr = m_addr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    chk("acc_stb", 32'(wb.s_wb_stb_o), 32'(exp_stb));
    if (exp_stb != 4'd0) begin
      chk("acc_adr", wb.s_wb_adr_o, a);
      chk("acc_dat", wb.s_wb_dat_o, d);
      chk("acc_sel", 32'(wb.s_wb_sel_o), 32'(s));
      chk("acc_we", 32'(wb.s_wb_we_o), 32'(w));
      chk("acc_cyc", 32'(wb.s_wb_cyc_o), 32'd1);
    end
    n = 1;
    while (!(wb.m_wb_ack_o === 1'b1 || wb.m_wb_err_o === 1'b1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("no_tmo", 32'(n < 200), 32'd1);
    chk("lat", 32'(n), 32'(exp_lat));
    chk("end_stb", 32'(wb.s_wb_stb_o), 32'd0);
    chk("end_cyc", 32'(wb.s_wb_cyc_o), 32'd0);
    @(negedge clk);
    wb.m_wb_cyc_i = 1'b0;
    wb.m_wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(wb.m_wb_ack_o), 32'd0);
    chk({tag, "_err"}, 32'(wb.m_wb_err_o), 32'd0);
    chk({tag, "_dat"}, wb.m_wb_dat_o, 32'd0);
    chk({tag, "_stb"}, 32'(wb.s_wb_stb_o), 32'd0);
    chk({tag, "_cyc"}, 32'(wb.s_wb_cyc_o), 32'd0);
    chk({tag, "_sadr"}, wb.s_wb_adr_o, 32'd0);
    chk({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_eadr"}, err_addr, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb.m_wb_adr_i = 32'd0;
    wb.m_wb_dat_i = 32'd0;
    wb.m_wb_we_i  = 1'b0;
    wb.m_wb_sel_i = 4'd0;
    wb.m_wb_cyc_i = 1'b0;
    wb.m_wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst");

    sl_mode  = 2'd1;
    sl_delay = 3;
    sl_data  = 32'h1234_5678;
    xfer(32'h8000_0010, 1'b0, 32'd0, 4'hF, 4'b1000,
         1'b0, 32'h1234_5678, 5);

    sl_delay = 0;
    sl_data  = 32'hCAFE_0001;
    xfer(32'hF000_0040, 1'b1, 32'hA5A5_0F0F, 4'hF, 4'b0001,
         1'b0, 32'hCAFE_0001, 2);

    xfer(32'h1000_0000, 1'b0, 32'd0, 4'hF, 4'b0000,
         1'b1, DEF, 1);

    sl_mode = 2'd0;
    xfer(32'hF800_0004, 1'b0, 32'd0, 4'hF, 4'b0100,
         1'b1, DEF, 17);

    sl_mode  = 2'd3;
    sl_delay = 1;
    xfer(32'hF000_0900, 1'b0, 32'd0, 4'hF, 4'b0010,
         1'b1, DEF, 3);

    sl_mode  = 2'd1;
    sl_delay = 2;
    sl_data  = 32'h5A5A_1234;
    xfer(32'h8000_1000, 1'b1, 32'h1122_3344, 4'h3, 4'b1000,
         1'b0, 32'h5A5A_1234, 4);

    // master abandons a stalled access
    sl_mode = 2'd0;
    @(negedge clk);
    wb.m_wb_adr_i = 32'hF000_0010;
    wb.m_wb_we_i  = 1'b0;
    wb.m_wb_cyc_i = 1'b1;
    wb.m_wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_acc", 32'(wb.s_wb_stb_o), 32'b0001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb.m_wb_cyc_i = 1'b0;
    wb.m_wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_stb", 32'(wb.s_wb_stb_o), 32'd0);
    chk("drop_cyc", 32'(wb.s_wb_cyc_o), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("drop_ecnt", 32'(err_cnt), 32'(m_cnt));
    chk("drop_ack", 32'(wb.m_wb_ack_o), 32'd0);
    chk("drop_err", 32'(wb.m_wb_err_o), 32'd0);

    // reset in the middle of a busy access
    @(negedge clk);
    wb.m_wb_adr_i = 32'h8000_0020;
    wb.m_wb_cyc_i = 1'b1;
    wb.m_wb_stb_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 32'(wb.s_wb_cyc_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    wb.m_wb_cyc_i = 1'b0;
    wb.m_wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mrst");
    m_cnt  = 16'd0;
    m_addr = 32'd0;
    @(negedge clk);
    rst = 1'b0;

    sl_mode  = 2'd1;
    sl_delay = 0;
    sl_data  = 32'h0BAD_C0DE;
    xfer(32'hF000_0800, 1'b0, 32'd0, 4'hF, 4'b0010,
         1'b0, 32'h0BAD_C0DE, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
